control_sequencer: RTL

Fetch–decode–execute control unit for the 16-bit accumulator computer; it fills the empty control stage between main memory and the ALU. It owns PC, IR, MAR, MBR and AC, reads instructions and operands from the synchronous main memory, drives the combinational ALU for arithmetic, and writes results back to memory. It runs one instruction at a time from PC 0 after reset until HALT.

---
 rtl/control_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control unit for the 16-bit accumulator computer
module control_sequencer #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [15:0]       mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   input  logic [15:0]       mem_rdata,
   output logic [3:0]        alu_op,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   input  logic [15:0]       alu_result,
   output logic [ADDR_W-1:0] pc_out,
   output logic [15:0]       ir_out,
   output logic [15:0]       ac_out,
   output logic              halted,
   output logic              illegal
);

   localparam logic [3:0] S_FETCH       = 4'd0;
   localparam logic [3:0] S_FETCH_RD    = 4'd1;
   localparam logic [3:0] S_FETCH_LATCH = 4'd2;
   localparam logic [3:0] S_DECODE      = 4'd3;
   localparam logic [3:0] S_EXEC_RD     = 4'd4;
   localparam logic [3:0] S_EXEC_LATCH  = 4'd5;
   localparam logic [3:0] S_EXEC        = 4'd6;
   localparam logic [3:0] S_STORE_WR    = 4'd7;
   localparam logic [3:0] S_HALTED      = 4'd8;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUBT  = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h7;
   localparam logic [3:0] OP_SKIP  = 4'h8;
   localparam logic [3:0] OP_JUMP  = 4'h9;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [3:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [15:0]       ir;
   logic [15:0]       mbr;
   logic [15:0]       ac;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic              legal_op;
   logic              skip_true;

   assign opcode  = ir[15:12];
   assign operand = ir[ADDR_W-1:0];

   // Opcode legality and SKIPCOND condition evaluation on the current AC
   always_comb begin
      legal_op  = 1'b0;
      skip_true = 1'b0;
      case (opcode)
         OP_LOAD, OP_STORE, OP_ADD, OP_SUBT, OP_HALT, OP_SKIP, OP_JUMP: legal_op = 1'b1;
         default: legal_op = 1'b0;
      endcase
      case (ir[11:10])
         2'b00:   skip_true = ac[15];
         2'b01:   skip_true = (ac == 16'h0000);
         2'b10:   skip_true = !ac[15] && (ac != 16'h0000);
         default: skip_true = 1'b0;
      endcase
   end

   // Sequencer state and architectural registers; HALTED freezes everything
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_FETCH;
         pc    <= '0;
         mar   <= '0;
         ir    <= '0;
         mbr   <= '0;
         ac    <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               mar   <= pc;
               state <= S_FETCH_RD;
            end
            S_FETCH_RD: state <= S_FETCH_LATCH;
            S_FETCH_LATCH: begin
               ir    <= mem_rdata;
               pc    <= pc + PC_ONE;
               state <= S_DECODE;
            end
            S_DECODE: begin
               mar <= operand;
               case (opcode)
                  OP_LOAD, OP_ADD, OP_SUBT: state <= S_EXEC_RD;
                  OP_STORE: state <= S_STORE_WR;
                  OP_HALT:  state <= S_HALTED;
                  OP_SKIP: begin
                     if (skip_true) pc <= pc + PC_ONE;
                     state <= S_FETCH;
                  end
                  OP_JUMP: begin
                     pc    <= operand;
                     state <= S_FETCH;
                  end
                  default: state <= S_FETCH;
               endcase
            end
            S_EXEC_RD: state <= S_EXEC_LATCH;
            S_EXEC_LATCH: begin
               mbr   <= mem_rdata;
               state <= S_EXEC;
            end
            S_EXEC: begin
               ac    <= (opcode == OP_LOAD) ? mbr : alu_result;
               state <= S_FETCH;
            end
            S_STORE_WR: state <= S_FETCH;
            S_HALTED:   state <= S_HALTED;
            default:    state <= S_FETCH;
         endcase
      end
   end

   assign mem_addr  = {{(16-ADDR_W){1'b0}}, mar};
   assign mem_wdata = ac;
   assign mem_we    = (state == S_STORE_WR);
   assign alu_op    = (opcode == OP_SUBT) ? 4'b0001 : 4'b0000;
   assign alu_a     = ac;
   assign alu_b     = mbr;
   assign pc_out    = pc;
   assign ir_out    = ir;
   assign ac_out    = ac;
   assign halted    = (state == S_HALTED);
   assign illegal   = (state == S_DECODE) && !legal_op;

endmodule
